// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multi-cycle MIPS main control unit
//
// Purpose: steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK, latching the decoder opcode at the end of DECODE and driving the
// datapath control strobes phase by phase. All outputs are registered and
// depend only on the state register and the latched opcode.
//
// Ports:
//   cu_clk           clock, rising edge
//   cu_rst           synchronous active-low reset
//   cu_i_run         level enable, sampled in IDLE and in final phases
//   cu_i_opcode      decoder opcode, captured at the edge that closes DECODE
//   cu_o_ce          fetch enable strobe
//   cu_o_reg_dst     1 = write rd, 0 = write rt
//   cu_o_reg_write   register-file write strobe
//   cu_o_alu_src     1 = immediate operand
//   cu_o_branch      branch-evaluate strobe
//   cu_o_mem_read    data-memory read strobe
//   cu_o_mem_write   data-memory write strobe
//   cu_o_mem_to_reg  1 = write-back from memory
//   cu_o_state       current state encoding
//   cu_o_instr_done  pulse in the final phase of each instruction
//   cu_o_illegal     sticky unsupported-opcode flag
//   cu_o_retired     completed-instruction counter (wraps)

module main_control_fsm #(
  parameter int OPCODE_WIDTH = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    cu_clk,
  input  logic                    cu_rst,
  input  logic                    cu_i_run,
  input  logic [OPCODE_WIDTH-1:0] cu_i_opcode,
  output logic                    cu_o_ce,
  output logic                    cu_o_reg_dst,
  output logic                    cu_o_reg_write,
  output logic                    cu_o_alu_src,
  output logic                    cu_o_branch,
  output logic                    cu_o_mem_read,
  output logic                    cu_o_mem_write,
  output logic                    cu_o_mem_to_reg,
  output logic [2:0]              cu_o_state,
  output logic                    cu_o_instr_done,
  output logic                    cu_o_illegal,
  output logic [CNT_WIDTH-1:0]    cu_o_retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);

  state_t                  r_state;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic                    r_ce;
  logic                    r_reg_dst;
  logic                    r_reg_write;
  logic                    r_alu_src;
  logic                    r_branch;
  logic                    r_mem_read;
  logic                    r_mem_write;
  logic                    r_mem_to_reg;
  logic                    r_instr_done;
  logic                    r_illegal;
  logic [CNT_WIDTH-1:0]    r_retired;

  state_t                  w_next_state;
  logic [OPCODE_WIDTH-1:0] w_next_op;
  logic                    w_ce;
  logic                    w_reg_dst;
  logic                    w_reg_write;
  logic                    w_alu_src;
  logic                    w_branch;
  logic                    w_mem_read;
  logic                    w_mem_write;
  logic                    w_mem_to_reg;
  logic                    w_instr_done;

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

  // Where a finished instruction goes next; run is only looked at here and in IDLE.
  function automatic state_t after_final(input logic run);
    return run ? S_FETCH : S_IDLE;
  endfunction

  // Next-state and opcode-latch selection.
  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op;
    case (r_state)
      S_IDLE:    if (cu_i_run) w_next_state = S_FETCH;
      S_FETCH:   w_next_state = S_DECODE;
      S_DECODE: begin
        w_next_op    = cu_i_opcode;
        w_next_state = is_legal(cu_i_opcode) ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        if (r_op == OP_BEQ)
          w_next_state = after_final(cu_i_run);
        else if ((r_op == OP_LW) || (r_op == OP_SW))
          w_next_state = S_MEMORY;
        else
          w_next_state = S_WRITEBACK;
      end
      S_MEMORY:    w_next_state = (r_op == OP_LW) ? S_WRITEBACK : after_final(cu_i_run);
      S_WRITEBACK: w_next_state = after_final(cu_i_run);
      S_HALT:      w_next_state = S_HALT;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Outputs for the state being entered, so the registered copies line up
  // with the state register and never see the inputs combinationally.
  always_comb begin
    w_ce         = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_instr_done = 1'b0;
    case (w_next_state)
      S_FETCH: w_ce = 1'b1;
      S_EXECUTE: begin
        w_alu_src    = (w_next_op == OP_LW) || (w_next_op == OP_SW) || (w_next_op == OP_ADDI);
        w_reg_dst    = (w_next_op == OP_RTYPE);
        w_mem_to_reg = (w_next_op == OP_LW);
        w_branch     = (w_next_op == OP_BEQ);
        w_instr_done = (w_next_op == OP_BEQ);
      end
      S_MEMORY: begin
        w_alu_src    = 1'b1;
        w_mem_to_reg = (w_next_op == OP_LW);
        w_mem_read   = (w_next_op == OP_LW);
        w_mem_write  = (w_next_op == OP_SW);
        w_instr_done = (w_next_op == OP_SW);
      end
      S_WRITEBACK: begin
        w_alu_src    = (w_next_op == OP_LW) || (w_next_op == OP_ADDI);
        w_reg_dst    = (w_next_op == OP_RTYPE);
        w_mem_to_reg = (w_next_op == OP_LW);
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cu_clk) begin
    if (!cu_rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_ce         <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_instr_done <= 1'b0;
      r_illegal    <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_op         <= w_next_op;
      r_ce         <= w_ce;
      r_reg_dst    <= w_reg_dst;
      r_reg_write  <= w_reg_write;
      r_alu_src    <= w_alu_src;
      r_branch     <= w_branch;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_mem_to_reg <= w_mem_to_reg;
      r_instr_done <= w_instr_done;
      // HALT is only left through reset, so the flag stays set once entered.
      r_illegal    <= r_illegal | (w_next_state == S_HALT);
      // r_instr_done marks the current cycle as a final phase; count on its closing edge.
      if (r_instr_done)
        r_retired <= r_retired + CNT_WIDTH'(1);
    end
  end

  assign cu_o_ce         = r_ce;
  assign cu_o_reg_dst    = r_reg_dst;
  assign cu_o_reg_write  = r_reg_write;
  assign cu_o_alu_src    = r_alu_src;
  assign cu_o_branch     = r_branch;
  assign cu_o_mem_read   = r_mem_read;
  assign cu_o_mem_write  = r_mem_write;
  assign cu_o_mem_to_reg = r_mem_to_reg;
  assign cu_o_state      = r_state;
  assign cu_o_instr_done = r_instr_done;
  assign cu_o_illegal    = r_illegal;
  assign cu_o_retired    = r_retired;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - scoreboard bench for main_control_fsm
module tb_main_control_fsm;

  localparam int CW = 3;  // narrow counter so wrap-around is exercised

  logic          cu_clk = 1'b0;
  logic          cu_rst;
  logic          cu_i_run;
  logic [5:0]    cu_i_opcode;
  logic          cu_o_ce, cu_o_reg_dst, cu_o_reg_write, cu_o_alu_src, cu_o_branch;
  logic          cu_o_mem_read, cu_o_mem_write, cu_o_mem_to_reg, cu_o_instr_done, cu_o_illegal;
  logic [2:0]    cu_o_state;
  logic [CW-1:0] cu_o_retired;

  main_control_fsm #(.OPCODE_WIDTH(6), .CNT_WIDTH(CW)) dut (
    .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_i_run(cu_i_run), .cu_i_opcode(cu_i_opcode),
    .cu_o_ce(cu_o_ce), .cu_o_reg_dst(cu_o_reg_dst), .cu_o_reg_write(cu_o_reg_write),
    .cu_o_alu_src(cu_o_alu_src), .cu_o_branch(cu_o_branch), .cu_o_mem_read(cu_o_mem_read),
    .cu_o_mem_write(cu_o_mem_write), .cu_o_mem_to_reg(cu_o_mem_to_reg), .cu_o_state(cu_o_state),
    .cu_o_instr_done(cu_o_instr_done), .cu_o_illegal(cu_o_illegal), .cu_o_retired(cu_o_retired)
  );

  always #5 cu_clk = ~cu_clk;

  // Per-cycle observation word: {state, illegal, done, m2r, mw, mr, br, as, rw, rd, ce}
  localparam logic [12:0] B_CE = 13'h001, B_RD = 13'h002, B_RW = 13'h004, B_AS = 13'h008;
  localparam logic [12:0] B_BR = 13'h010, B_MR = 13'h020, B_MW = 13'h040, B_M2R = 13'h080;
  localparam logic [12:0] B_DN = 13'h100, B_IL = 13'h200;

  typedef struct {
    logic [64:0]   tr;
    int            len;
    logic [CW-1:0] ret_before;
  } item_t;

  item_t         exp_q[$];
  logic [5:0]    plan_q[$];
  logic [CW-1:0] model_retired;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            stray_cnt = 0;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [12:0] st(input int s);
    return 13'(s) << 10;
  endfunction

  // Reference model: phase-by-phase control word sequence of one instruction.
  function automatic logic [64:0] exp_trace(input logic [5:0] op, output int len);
    logic [64:0] t;
    t = '0;
    t[0 +: 13]  = B_CE | st(1);
    t[13 +: 13] = st(2);
    case (op)
      6'b000000: begin
        t[26 +: 13] = B_RD | st(3);
        t[39 +: 13] = B_RD | B_RW | B_DN | st(5);
        len = 4;
      end
      6'b001000: begin
        t[26 +: 13] = B_AS | st(3);
        t[39 +: 13] = B_AS | B_RW | B_DN | st(5);
        len = 4;
      end
      6'b100011: begin
        t[26 +: 13] = B_AS | B_M2R | st(3);
        t[39 +: 13] = B_AS | B_M2R | B_MR | st(4);
        t[52 +: 13] = B_AS | B_M2R | B_RW | B_DN | st(5);
        len = 5;
      end
      6'b101011: begin
        t[26 +: 13] = B_AS | st(3);
        t[39 +: 13] = B_AS | B_MW | B_DN | st(4);
        len = 4;
      end
      6'b000100: begin
        t[26 +: 13] = B_BR | B_DN | st(3);
        len = 3;
      end
      default: begin
        t[26 +: 13] = B_IL | st(6);
        len = 3;
      end
    endcase
    return t;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h08;
  endfunction

  task automatic push_expected(input logic [5:0] op);
    item_t it;
    it.tr = exp_trace(op, it.len);
    it.ret_before = model_retired;
    exp_q.push_back(it);
    if (legal(op)) model_retired = model_retired + 1'b1;
  endtask

  function automatic logic [12:0] obs_mask();
    return {cu_o_state, cu_o_illegal, cu_o_instr_done, cu_o_mem_to_reg, cu_o_mem_write,
            cu_o_mem_read, cu_o_branch, cu_o_alu_src, cu_o_reg_write, cu_o_reg_dst, cu_o_ce};
  endfunction

  // Monitor: captures each instruction from its FETCH to its final/HALT cycle and scores it.
  bit          mon_cap = 0;
  bit          mon_prev_done = 0;
  int          mon_idx = 0;
  logic [64:0] mon_obs;
  always begin
    logic run_e, rst_e;
    logic [12:0] m;
    item_t it;
    @(posedge cu_clk);
    run_e = cu_i_run;
    rst_e = cu_rst;
    #1;
    if (!rst_e) begin
      mon_cap = 0;
      mon_prev_done = 0;
    end else begin
      m = obs_mask();
      if (mon_prev_done)
        check(cu_o_state == (run_e ? 3'd1 : 3'd0), "state_after_final", cu_o_state, run_e ? 1 : 0);
      mon_prev_done = cu_o_instr_done;
      if (!mon_cap && cu_o_ce) begin
        mon_cap = 1;
        mon_idx = 0;
        mon_obs = '0;
      end
      if (mon_cap) begin
        mon_obs[mon_idx*13 +: 13] = m;
        mon_idx++;
        if (cu_o_instr_done || cu_o_state == 3'd6) begin
          mon_cap = 0;
          if (exp_q.size() == 0) begin
            check(0, "unexpected_completion", mon_obs, 0);
          end else begin
            it = exp_q.pop_front();
            check(mon_idx == it.len, "instr_latency", mon_idx, it.len);
            check(mon_obs == it.tr, "instr_trace", mon_obs, it.tr);
            check(cu_o_retired == it.ret_before, "retired_at_final", cu_o_retired, it.ret_before);
          end
        end else if (mon_idx >= 5) begin
          mon_cap = 0;
          check(0, "instr_overrun", mon_obs, 0);
        end
      end else if (m[8:1] != 0) begin
        stray_cnt++;
      end
    end
  end

  // Issues the planned opcodes; mode 0 holds run high, mode 1 randomises it.
  task automatic drive(input int mode, input int budget);
    int cyc;
    logic [5:0] op;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge cu_clk);
      cyc++;
      if (cu_o_ce) begin
        if (plan_q.size() == 0) begin
          check(0, "unplanned_fetch", 1, 0);
        end else begin
          op = plan_q.pop_front();
          cu_i_opcode = op;
          push_expected(op);
        end
      end else if (cu_o_state != 3'd2) begin
        cu_i_opcode = 6'($urandom);
      end
      if (plan_q.size() == 0) begin
        if (cu_o_instr_done || cu_o_state == 3'd4 || cu_o_state == 3'd0) cu_i_run = 1'b0;
      end else if (mode == 1) begin
        if (cu_o_instr_done || cu_o_state == 3'd0) cu_i_run = ($urandom_range(3) != 0);
        else cu_i_run = 1'($urandom_range(1));
      end else begin
        cu_i_run = 1'b1;
      end
      if (plan_q.size() == 0 && exp_q.size() == 0 && (cu_o_state == 3'd0 || cu_o_state == 3'd6))
        break;
    end
    check(cyc < budget, "drive_budget", cyc, budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[5];
    int bad;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04; ops[4] = 6'h08;
    model_retired = '0;
    cu_rst = 1'b0;
    cu_i_run = 1'b1;
    cu_i_opcode = 6'h00;
    repeat (2) @(negedge cu_clk);
    check(cu_o_state == 3'd0, "reset_state", cu_o_state, 0);
    check(obs_mask() == 13'h0, "reset_outputs", obs_mask(), 0);
    check(cu_o_retired == 0, "reset_retired", cu_o_retired, 0);

    cu_rst = 1'b1;
    plan_q.push_back(6'h00);
    @(posedge cu_clk); #1;
    check(cu_o_state == 3'd1 && cu_o_ce, "first_fetch", {cu_o_state, cu_o_ce}, 4'b0011);
    drive(0, 50);
    check(cu_o_retired == model_retired, "retired_rtype", cu_o_retired, model_retired);

    plan_q.push_back(6'h23); plan_q.push_back(6'h2b);
    drive(0, 50);
    check(cu_o_retired == model_retired, "retired_lw_sw", cu_o_retired, model_retired);

    plan_q.push_back(6'h04); plan_q.push_back(6'h08);
    drive(0, 50);

    plan_q.push_back(6'h23);
    drive(0, 50);
    check(cu_o_state == 3'd0, "lw_run_drop_idle", cu_o_state, 0);
    check(cu_o_retired == model_retired, "retired_lw_drop", cu_o_retired, model_retired);

    for (int i = 0; i < 40; i++) plan_q.push_back(ops[$urandom_range(4)]);
    drive(1, 2000);
    check(cu_o_retired == model_retired, "retired_random", cu_o_retired, model_retired);

    plan_q.push_back(6'h3f);
    drive(0, 50);
    check(cu_o_state == 3'd6 && cu_o_illegal, "illegal_halt", {cu_o_state, cu_o_illegal}, 4'b1101);
    cu_i_run = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge cu_clk);
      if (cu_o_ce || cu_o_state != 3'd6) bad++;
    end
    check(bad == 0, "halt_stays", bad, 0);
    check(cu_o_retired == model_retired, "halt_retired", cu_o_retired, model_retired);
    cu_rst = 1'b0;
    @(negedge cu_clk);
    check(cu_o_illegal == 0 && cu_o_state == 3'd0, "reset_clears_illegal",
          {cu_o_state, cu_o_illegal}, 0);
    check(cu_o_retired == 0, "reset_clears_retired", cu_o_retired, 0);
    model_retired = '0;
    cu_rst = 1'b1;

    cu_i_opcode = 6'h00;
    cu_i_run = 1'b1;
    bad = 0;
    while (cu_o_state != 3'd3 && bad < 10) begin
      @(negedge cu_clk);
      bad++;
    end
    check(cu_o_state == 3'd3, "reach_execute", cu_o_state, 3);
    cu_rst = 1'b0;
    cu_i_run = 1'b0;
    @(posedge cu_clk); #1;
    check(cu_o_state == 3'd0 && obs_mask() == 13'h0, "reset_in_execute", obs_mask(), 0);
    @(negedge cu_clk);
    cu_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge cu_clk);
      if (cu_o_reg_write || cu_o_state != 3'd0) bad++;
    end
    check(bad == 0, "abandoned_no_writeback", bad, 0);

    check(stray_cnt == 0, "stray_strobes", stray_cnt, 0);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
